// File: rtl/spike_rate_encoder.sv
// Rate-coded spike source: per-channel rates loaded via valid/ready, applied per frame.
// Optional LFSR (Bernoulli) spike mode is enabled by defining SPIKE_ENC_STOCHASTIC_EN.
module spike_rate_encoder #(
  parameter int NUM_CH = 3,
  parameter int RATE_W = 4,
  parameter int WINDOW = 16
`ifdef SPIKE_ENC_STOCHASTIC_EN
  , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic                     rate_valid,
  output logic                     rate_ready,
  input  logic [NUM_CH*RATE_W-1:0] rate_data,
  output logic [NUM_CH-1:0]        spike_out,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int RW    = NUM_CH * RATE_W;
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [RW-1:0]     shadow_q, shadow_d;
  logic [RW-1:0]     rate_q, rate_d;
  logic [NUM_CH-1:0] spike_q, spike_d;
  logic              reload, step, xfer;
`ifdef SPIKE_ENC_STOCHASTIC_EN
  logic [15:0]       lfsr_q, lfsr_d;
`else
  logic [RW-1:0]     acc_q, acc_d;
`endif

  assign rate_ready = !pend_q;
  assign busy       = (state_q == RUN);
  assign spike_out  = spike_q;
  assign xfer       = rate_valid && !pend_q;

  // The accumulate for RUN cycle k happens on the edge entering it,
  // so the spike register shows cycle k's carry during cycle k.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    shadow_d   = shadow_q;
    rate_d     = rate_q;
    spike_d    = '0;
    frame_done = 1'b0;
    reload     = 1'b0;
    step       = 1'b0;
`ifdef SPIKE_ENC_STOCHASTIC_EN
    lfsr_d     = lfsr_q;
`else
    acc_d      = acc_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          reload  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          frame_done = 1'b1;
          if (continuous) reload  = 1'b1;
          else            state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    if (reload) begin
      step  = 1'b1;
      cnt_d = '0;
      if (pend_q) begin
        rate_d = shadow_q;
        pend_d = 1'b0;
      end
    end

    // xfer needs !pend_q, so it never collides with a consuming reload
    if (xfer) begin
      shadow_d = rate_data;
      pend_d   = 1'b1;
    end

    if (step) begin
`ifdef SPIKE_ENC_STOCHASTIC_EN
      for (int c = 0; c < NUM_CH; c++) begin
        spike_d[c] = rate_d[c*RATE_W +: RATE_W] >
                     (lfsr_q[c*RATE_W +: RATE_W] ^ lfsr_q[15 -: RATE_W]);
      end
      lfsr_d = {lfsr_q[14:0],
                lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`else
      for (int c = 0; c < NUM_CH; c++) begin
        {spike_d[c], acc_d[c*RATE_W +: RATE_W]} =
          {1'b0, (reload ? {RATE_W{1'b0}} : acc_q[c*RATE_W +: RATE_W])} +
          {1'b0, rate_d[c*RATE_W +: RATE_W]};
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      rate_q   <= '0;
      spike_q  <= '0;
`ifdef SPIKE_ENC_STOCHASTIC_EN
      lfsr_q   <= LFSR_SEED;
`else
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      rate_q   <= rate_d;
      spike_q  <= spike_d;
`ifdef SPIKE_ENC_STOCHASTIC_EN
      lfsr_q   <= lfsr_d;
`else
      acc_q    <= acc_d;
`endif
    end
  end

endmodule
